// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons.
// One shared leak/integrate/threshold datapath walks the neurons in index
// order each timestep; spiking neurons are reported as ID events.
module lif_neuron_array #(
  parameter int N_NEURONS      = 8,
  parameter int CURRENT_WIDTH  = 8,
  parameter int MEMBRANE_WIDTH = 16,
  parameter int LEAK_SHIFT     = 3,
  parameter int V_THRESH       = 300,
  parameter int V_RESET        = 0,
  parameter int REFRACT_STEPS  = 2,
  parameter int ID_W           = $clog2(N_NEURONS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step_start,
  input  logic                     in_valid,
  input  logic [CURRENT_WIDTH-1:0] in_current,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [ID_W-1:0]          cur_id,
  output logic                     step_done,
  output logic [ID_W:0]            step_spikes
);

  localparam int MW   = MEMBRANE_WIDTH;
  localparam int CW   = CURRENT_WIDTH;
  localparam int RC_W = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;

  localparam logic signed [MW-1:0]   VRST    = MW'(V_RESET);
  localparam logic signed [MW-1:0]   VTH     = MW'(V_THRESH);
  localparam logic [RC_W-1:0]        RC_INIT = RC_W'(REFRACT_STEPS);
  // Saturation bounds expressed at the two-bit-wider intermediate width
  localparam logic signed [MW+1:0]   SMAX    = {3'b000, {(MW-1){1'b1}}};
  localparam logic signed [MW+1:0]   SMIN    = {3'b111, {(MW-1){1'b0}}};
  localparam logic [ID_W-1:0]        LAST    = ID_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} state_t;

  state_t               state;
  logic [ID_W-1:0]      idx;
  logic [ID_W:0]        cnt;

  logic [MW-1:0]        v_q  [N_NEURONS];
  logic [RC_W-1:0]      rc_q [N_NEURONS];

  logic signed [MW-1:0] v_cur, leak, s_sat, v_d;
  logic signed [MW+1:0] s_wide;
  logic [RC_W-1:0]      rc_cur, rc_d;
  logic                 refr, spike, acc, last;

  // Shared neuron datapath: leak, integrate, saturate, threshold
  always_comb begin
    v_cur  = v_q[idx];
    rc_cur = rc_q[idx];
    leak   = v_cur >>> LEAK_SHIFT;
    s_wide = {{2{v_cur[MW-1]}}, v_cur}
           - {{2{leak[MW-1]}}, leak}
           + {{(MW+2-CW){in_current[CW-1]}}, in_current};
    if (s_wide > SMAX)      s_sat = SMAX[MW-1:0];
    else if (s_wide < SMIN) s_sat = SMIN[MW-1:0];
    else                    s_sat = s_wide[MW-1:0];
    refr  = (rc_cur != '0);
    spike = !refr && (s_sat >= VTH);
    v_d   = (refr || spike) ? VRST : s_sat;
    if (refr)       rc_d = rc_cur - RC_W'(1);
    else if (spike) rc_d = RC_INIT;
    else            rc_d = '0;
  end

  assign acc  = (state == UPDATE) && in_valid;
  assign last = (idx == LAST);

  // Neuron state: only the neuron currently consuming current is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]  <= VRST;
        rc_q[i] <= '0;
      end
    end else if (acc) begin
      v_q[idx]  <= v_d;
      rc_q[idx] <= rc_d;
    end
  end

  // Step sequencer; spike count is latched on entry to DONE so it is
  // already valid while step_done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      step_spikes <= '0;
    end else begin
      case (state)
        IDLE: if (step_start) begin
          state <= UPDATE;
          idx   <= '0;
          cnt   <= '0;
        end
        UPDATE: if (acc) begin
          if (spike) begin
            cnt   <= cnt + (ID_W+1)'(1);
            state <= EMIT;
          end else if (last) begin
            state       <= DONE;
            step_spikes <= cnt;
          end else begin
            idx <= idx + ID_W'(1);
          end
        end
        EMIT: if (out_ready) begin
          if (last) begin
            state       <= DONE;
            step_spikes <= cnt;
          end else begin
            idx   <= idx + ID_W'(1);
            state <= UPDATE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == UPDATE);
  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign step_done = (state == DONE);
  assign out_id    = idx;
  assign cur_id    = idx;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: a 16-bit membrane instance (0) and a 10-bit
// membrane instance (1) for saturation; expected spike IDs come from a
// behavioral model and are queued per step, then popped on each event.
module tb_lif_neuron_array;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      step_start, in_valid, in_ready, out_valid, out_ready, busy, step_done;
  logic [1:0][7:0] in_current;
  logic [1:0][1:0] out_id, cur_id;
  logic [1:0][2:0] step_spikes;

  int nvec = 0;
  int nerr = 0;

  int mv  [2][4];
  int mrc [2][4];
  int mw  [2] = '{16, 10};

  always #5 clk = ~clk;

  lif_neuron_array #(.N_NEURONS(4), .CURRENT_WIDTH(8), .MEMBRANE_WIDTH(16),
    .LEAK_SHIFT(3), .V_THRESH(300), .V_RESET(0), .REFRACT_STEPS(2)) dut (
    .clk(clk), .rst_n(rst_n), .step_start(step_start[0]), .in_valid(in_valid[0]),
    .in_current(in_current[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
    .out_id(out_id[0]), .out_ready(out_ready[0]), .busy(busy[0]), .cur_id(cur_id[0]),
    .step_done(step_done[0]), .step_spikes(step_spikes[0]));

  lif_neuron_array #(.N_NEURONS(4), .CURRENT_WIDTH(8), .MEMBRANE_WIDTH(10),
    .LEAK_SHIFT(3), .V_THRESH(300), .V_RESET(0), .REFRACT_STEPS(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .step_start(step_start[1]), .in_valid(in_valid[1]),
    .in_current(in_current[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
    .out_id(out_id[1]), .out_ready(out_ready[1]), .busy(busy[1]), .cur_id(cur_id[1]),
    .step_done(step_done[1]), .step_spikes(step_spikes[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) begin
        mv[s][i]  = 0;
        mrc[s][i] = 0;
      end
  endtask

  task automatic chk_idle(input int sel);
    chk("rst_in_ready",    in_ready[sel],    0);
    chk("rst_out_valid",   out_valid[sel],   0);
    chk("rst_out_id",      out_id[sel],      0);
    chk("rst_busy",        busy[sel],        0);
    chk("rst_cur_id",      cur_id[sel],      0);
    chk("rst_step_done",   step_done[sel],   0);
    chk("rst_step_spikes", step_spikes[sel], 0);
  endtask

  // One timestep on instance sel. bp: cycles of out_ready=0 on the first
  // event; extra_start: cycle at which step_start is re-pulsed while busy;
  // abort: assert reset while the first event is pending.
  task automatic run_step(input int sel, input int cur[4], input int bp,
                          input int extra_start, input bit abort);
    int exq[$];
    int nspk = 0;
    int nxt  = 0;
    int cyc  = 0;
    int bpl  = bp;
    int lo, hi, s;
    bit done = 0;
    lo = -(1 << (mw[sel] - 1));
    hi = (1 << (mw[sel] - 1)) - 1;
    for (int i = 0; i < 4; i++) begin
      if (mrc[sel][i] > 0) begin
        mv[sel][i] = 0;
        mrc[sel][i]--;
      end else begin
        s = mv[sel][i] - (mv[sel][i] >>> 3) + cur[i];
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        if (s >= 300) begin
          mv[sel][i]  = 0;
          mrc[sel][i] = 2;
          exq.push_back(i);
          nspk++;
        end else mv[sel][i] = s;
      end
    end
    @(negedge clk);
    step_start[sel] = 1'b1;
    out_ready[sel]  = 1'b1;
    @(negedge clk);
    step_start[sel] = 1'b0;
    while (!done && cyc < 200) begin
      cyc++;
      if (extra_start > 0 && cyc == extra_start)     step_start[sel] = 1'b1;
      if (extra_start > 0 && cyc == extra_start + 1) step_start[sel] = 1'b0;
      if (cyc == 1) chk("start_latency", in_ready[sel], 1);
      if (step_done[sel]) begin
        done = 1;
        chk("step_spikes", step_spikes[sel], nspk);
        chk("events_left", exq.size(), 0);
        chk("busy_at_done", busy[sel], 1);
        if (abort) chk("abort_missed", step_done[sel], 0);
        if (nspk == 0) chk("step_length", cyc, 5);
      end else begin
        chk("busy", busy[sel], 1);
        if (in_ready[sel]) begin
          chk("cur_id", cur_id[sel], nxt);
          in_valid[sel]   = 1'b1;
          in_current[sel] = (nxt < 4) ? 8'(cur[nxt]) : 8'd0;
          nxt++;
        end else begin
          // junk word that must be ignored outside UPDATE
          in_valid[sel]   = 1'b1;
          in_current[sel] = 8'd100;
        end
        if (out_valid[sel]) begin
          if (exq.size() == 0) begin
            chk("extra_event", out_valid[sel], 0);
            out_ready[sel] = 1'b1;
          end else if (abort) begin
            out_ready[sel] = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            chk("abort_out_valid", out_valid[sel], 0);
            chk("abort_busy",      busy[sel],      0);
            chk("abort_in_ready",  in_ready[sel],  0);
            chk("abort_out_id",    out_id[sel],    0);
            done = 1;
          end else if (bpl > 0) begin
            out_ready[sel] = 1'b0;
            chk("bp_out_id",   out_id[sel],   exq[0]);
            chk("bp_in_ready", in_ready[sel], 0);
            bpl--;
          end else begin
            out_ready[sel] = 1'b1;
            chk("out_id", out_id[sel], exq.pop_front());
          end
        end else out_ready[sel] = 1'b1;
        if (!done) @(negedge clk);
      end
    end
    if (!done) chk("timeout", step_done[sel], 1);
    in_valid[sel] = 1'b0;
    if (extra_start > 0 && !abort)
      repeat (3) begin
        @(negedge clk);
        chk("no_extra_step", busy[sel], 0);
      end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c[4];
    rst_n = 1'b0;
    step_start = '0; in_valid = '0; out_ready = '0; in_current = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_idle(0);
    chk_idle(1);

    // all-zero step
    run_step(0, '{0, 0, 0, 0}, 0, 0, 0);
    // integrate and refractory on neuron 0
    repeat (8) run_step(0, '{127, 0, 0, 0}, 0, 0, 0);
    // backpressure on neuron 2's spike
    repeat (2) run_step(0, '{0, 0, 127, 0}, 0, 0, 0);
    run_step(0, '{0, 0, 127, 0}, 5, 0, 0);
    // two spikes in one step
    repeat (3) run_step(0, '{0, 127, 0, 127}, 0, 0, 0);
    // step_start while busy must not start another step
    run_step(0, '{0, 0, 0, 0}, 0, 2, 0);
    // reset while an event is pending
    repeat (2) run_step(0, '{0, 0, 127, 0}, 0, 0, 0);
    run_step(0, '{0, 0, 127, 0}, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk_idle(0);
    run_step(0, '{0, 0, 0, 0}, 0, 0, 0);
    repeat (3) run_step(0, '{127, 0, 0, 0}, 0, 0, 0);
    // random currents
    repeat (8) begin
      for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 255)) - 128;
      run_step(0, c, 0, 0, 0);
    end
    // saturation on the 10-bit instance, then recovery timing from the floor
    repeat (40) run_step(1, '{-128, -128, -128, -128}, 0, 0, 0);
    repeat (6) run_step(1, '{127, 127, 127, 127}, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Time-multiplexed array of N leaky integrate-and-fire neurons in signed fixed-point, replacing per-neuron real-valued models with a synthesizable shared datapath. One `step_start` pulse runs one simulation timestep. Each neuron's input current is consumed in ascending index order through a valid/ready stream. Spikes leave as neuron-ID events on a second valid/ready stream, which feeds the spike router in the SNN core.

## Interface
- `N_NEURONS`, 8: number of neurons. Must be ≥2.
- `CURRENT_WIDTH`, 8: signed input current width, in membrane LSB units.
- `MEMBRANE_WIDTH`, 16: signed membrane register width.
- `LEAK_SHIFT`, 3: leak shift; tau = 2^LEAK_SHIFT timesteps.
- `V_THRESH`, 300: signed firing threshold. Must be within membrane range.
- `V_RESET`, 0: signed post-spike and reset potential.
- `REFRACT_STEPS`, 2: number of timesteps held at `V_RESET` after a spike. 0 means no refractory period.
- `ID_W`, $clog2(N_NEURONS): width of the neuron index.
- `clk`  in  1: the block's single clock. Rising-edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `step_start`  in  1: pulse that starts a timestep. Ignored unless `busy`=0.
- `in_valid`  in  1: current word valid.
- `in_current`  in  CURRENT_WIDTH: signed current for neuron `cur_id`.
- `in_ready`  out  1: block accepts the current word.
- `out_valid`  out  1: spike event pending.
- `out_id`  out  ID_W: index of the neuron that spiked.
- `out_ready`  in  1: downstream accepts the spike event.
- `busy`  out  1: a timestep is in progress.
- `cur_id`  out  ID_W: index of the neuron awaiting current.
- `step_done`  out  1: one-cycle pulse when a timestep completes.
- `step_spikes`  out  ID_W+1: spike count of the last completed step. Held until the next `step_done`.

## Operation
- **State storage:**
  - Membrane array `v[N]` holds MEMBRANE_WIDTH-bit signed values.
  - Refractory counters `rc[N]` are wide enough for REFRACT_STEPS.
  - Both are flops and both are reset asynchronously (`v[i]`=V_RESET, `rc[i]`=0).
- **FSM states:** IDLE, UPDATE, EMIT, DONE.
  - IDLE -> UPDATE on `step_start`. This sets idx=0 and clears the spike counter.
  - UPDATE: `in_ready`=1. On an in handshake, neuron idx is updated as described below. Then:
    - On a spike: -> EMIT.
    - Else, if idx=N-1: -> DONE.
    - Else: idx+1.
  - EMIT: `out_valid`=1, `out_id`=idx, `in_ready`=0. On an out handshake:
    - If idx=N-1: -> DONE.
    - Else: idx+1, -> UPDATE.
  - DONE: `step_done`=1 for one cycle, `step_spikes` is latched, -> IDLE.
- **Neuron update** (I = sign-extended `in_current`):
  - If `rc`>0: `v` is set to V_RESET and `rc` is decremented. The current is consumed and ignored, and no spike occurs.
  - Else compute s = v − (v >>> LEAK_SHIFT) + I.
    - The arithmetic shift rounds toward −inf.
    - s is computed at MEMBRANE_WIDTH+2 bits, then saturated to the signed MEMBRANE_WIDTH range. It never wraps.
  - If s ≥ V_THRESH: spike. `v`=V_RESET, `rc`=REFRACT_STEPS, spike counter +1.
  - Else `v`=s.
- **Control signals:**
  - `busy`=1 in every state except IDLE.
  - `cur_id`=idx.
  - `step_start` is ignored while `busy`=1.
  - `in_valid` is ignored outside UPDATE.

## Timing
- **Reset values:**
  - `in_ready`=0, `out_valid`=0, `out_id`=0, `busy`=0, `cur_id`=0, `step_done`=0, `step_spikes`=0. The FSM is in IDLE.
  - Reset takes effect immediately when asserted mid-step. The step is abandoned and no `step_done` is issued.
- **Start latency:** `step_start` sampled at edge k gives `in_ready`=1 from cycle k+1.
- **Throughput:** one neuron per cycle when no neurons spike.
  - A spiking neuron accepted at edge c gives `out_valid`=1 from cycle c+1. It is held with a stable `out_id` until `out_ready`.
  - `in_ready` rises the cycle after the out handshake.
- **Best-case step length:** a step with no spikes and continuous `in_valid` has `step_done` asserted N+1 cycles after `step_start` is sampled.
- **Ordering and persistence:**
  - Spike events are strictly ascending in ID within a step. There is at most one event per neuron per step.
  - `v` and `rc` persist across steps. They are cleared only by reset.

## Test plan
All scenarios use N=4, CW=8, MW=16, LEAK_SHIFT=3, V_THRESH=300, V_RESET=0, REFRACT_STEPS=2 unless stated otherwise.
- **Reset:** release reset, idle 5 cycles -> all outputs 0. Then apply a step with all currents 0 -> no spikes, `step_done` 5 cycles after `step_start`, `step_spikes`=0.
- **Integrate and refractory:** neuron 0 gets I=127 every step, the others get 0.
  - v goes 127, then 239, then spike at step 3 with `out_id`=0.
  - Steps 4–5 have no spike despite I=127.
  - Step 6 gives v=127, step 8 spikes again.
- **Backpressure:** hold `out_ready`=0 for 5 cycles during a spike -> `out_valid` stays 1, `out_id` is stable, `in_ready`=0, no `step_done`. Releasing `out_ready` resumes with the next neuron.
- **Multiple spikes:** neurons 1 and 3 are pre-charged to spike in the same step -> events with `out_id` 1 then 3, and `step_spikes`=2.
- **Saturation:** with MW=10, drive I=−128 for 40 steps -> v reaches −512 and stays there. No wrap to positive, no spike.
- **Reset mid-step and ignored start:** assert `rst_n`=0 during EMIT -> `out_valid` drops immediately, and the next step behaves as from reset. Also, a `step_start` pulsed while `busy`=1 starts no extra step.
